// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the two-way set-associative cache.
//   - cache_state_e : controller states (IDLE, LOOKUP, WRITEBACK, FILL, RESPOND)
//   - DEF_*         : default geometry used as the top-level parameter defaults
//   - cache_tag / cache_index / cache_word : address field extraction; they take
//     the field widths as arguments so any legal geometry can use them, and
//     callers size-cast the 64-bit result down to the field width.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    RESPOND   = 3'd4
  } cache_state_e;

  // Working width of the field helpers; wide enough for any practical address.
  localparam int unsigned FIELD_CALC_W = 32'd64;
  // Byte-within-word bits below the word select (32-bit words).
  localparam int unsigned WORD_BYTE_W  = 32'd2;
  localparam int unsigned BYTES_PER_WORD = 32'd4;

  localparam int unsigned DEF_ADDR_W   = 32'd27;
  localparam int unsigned DEF_DATA_W   = 32'd32;
  localparam int unsigned DEF_LINE_W   = 32'd128;
  localparam int unsigned DEF_SETS     = 32'd256;
  localparam int unsigned DEF_WAYS     = 32'd2;
  localparam int unsigned DEF_OFFSET_W = $clog2(DEF_LINE_W / 32'd8);
  localparam int unsigned DEF_INDEX_W  = $clog2(DEF_SETS);
  localparam int unsigned DEF_TAG_W    = DEF_ADDR_W - DEF_OFFSET_W - DEF_INDEX_W;

  // Tag: everything above the offset and index fields.
  function automatic logic [FIELD_CALC_W-1:0] cache_tag(
    input logic [FIELD_CALC_W-1:0] a,
    input int unsigned             off_w,
    input int unsigned             idx_w
  );
    return a >> (off_w + idx_w);
  endfunction

  // Index: the idx_w bits directly above the line offset.
  function automatic logic [FIELD_CALC_W-1:0] cache_index(
    input logic [FIELD_CALC_W-1:0] a,
    input int unsigned             off_w,
    input int unsigned             idx_w
  );
    return (a >> off_w) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Word select: offset bits above the byte-within-word bits.
  function automatic logic [FIELD_CALC_W-1:0] cache_word(
    input logic [FIELD_CALC_W-1:0] a,
    input int unsigned             off_w
  );
    return (a >> WORD_BYTE_W) & ((64'd1 << (off_w - WORD_BYTE_W)) - 64'd1);
  endfunction

endpackage

// File: rtl/cache_way.sv
// cache_way: storage for one way of the cache (valid, dirty, tag and line data
// for every set). Reads are combinational on index; writes happen on clk.
//   clk, rst          : clock and synchronous active-high reset (valid/dirty only)
//   index             : set being looked up and written
//   fill_en           : install wr_tag/wr_line, mark valid and clean
//   store_en          : replace the line with wr_line and mark dirty
//   valid, dirty, tag, line : contents of the addressed set
module cache_way
  import cache_pkg::*;
#(
  parameter int unsigned TAG_W   = DEF_TAG_W,
  parameter int unsigned INDEX_W = DEF_INDEX_W,
  parameter int unsigned LINE_W  = DEF_LINE_W,
  parameter int unsigned SETS    = DEF_SETS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic               fill_en,
  input  logic               store_en,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line,
  output logic               valid,
  output logic               dirty,
  output logic [TAG_W-1:0]   tag,
  output logic [LINE_W-1:0]  line
);

  logic [SETS-1:0]   valid_r;
  logic [SETS-1:0]   dirty_r;
  logic [TAG_W-1:0]  tag_mem_r  [SETS];
  logic [LINE_W-1:0] data_mem_r [SETS];

  // Per-set status bits; the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (fill_en) begin
      valid_r[index] <= 1'b1;
      dirty_r[index] <= 1'b0;
    end else if (store_en) begin
      dirty_r[index] <= 1'b1;
    end
  end

  // Tag and data arrays: left uninitialised, qualified by valid_r.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem_r[index]  <= wr_tag;
      data_mem_r[index] <= wr_line;
    end else if (store_en) begin
      data_mem_r[index] <= wr_line;
    end
  end

  assign valid = valid_r[index];
  assign dirty = dirty_r[index];
  assign tag   = tag_mem_r[index];
  assign line  = data_mem_r[index];

endmodule

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: two-way set-associative write-back / write-allocate cache
// between a 32-bit CPU port and a line-wide DDR2 controller port.
//   CPU side  : addr, write_data, byte_en, write, enable -> busy, read_data, available
//   DDR2 side : ddr2_addr, to_ddr2_data, ddr2_enable, ddr2_read -> ddr2_data, ddr2_available
// A request is accepted when enable=1 and busy=0; busy then stays high until the
// edge after the one-cycle available pulse. Misses optionally write back a dirty
// victim, then fill and re-run the lookup, which is then guaranteed to hit.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LINE_W = DEF_LINE_W,
  parameter int unsigned SETS   = DEF_SETS,
  parameter int unsigned WAYS   = DEF_WAYS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [3:0]        byte_en,
  input  logic              write,
  input  logic              enable,
  output logic              busy,
  output logic [DATA_W-1:0] read_data,
  output logic              available,
  output logic [ADDR_W-1:0] ddr2_addr,
  output logic [LINE_W-1:0] to_ddr2_data,
  output logic              ddr2_enable,
  output logic              ddr2_read,
  input  logic [LINE_W-1:0] ddr2_data,
  input  logic              ddr2_available
);

  localparam int unsigned OFFSET_W = $clog2(LINE_W / 32'd8);
  localparam int unsigned WSEL_W   = OFFSET_W - WORD_BYTE_W;
  localparam int unsigned INDEX_W  = $clog2(SETS);
  localparam int unsigned TAG_W    = ADDR_W - OFFSET_W - INDEX_W;

  cache_state_e      state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [3:0]        be_r;
  logic              write_r;
  logic              victim_r;
  logic [SETS-1:0]   lru_r;     // per set: the way to evict next

  logic              busy_r;
  logic              available_r;
  logic [DATA_W-1:0] read_data_r;
  logic [ADDR_W-1:0] ddr2_addr_r;
  logic [LINE_W-1:0] to_ddr2_data_r;
  logic              ddr2_enable_r;
  logic              ddr2_read_r;

  logic [INDEX_W-1:0] index_s;
  logic [TAG_W-1:0]   tag_s;
  logic [WSEL_W-1:0]  wsel_s;

  logic [WAYS-1:0]   way_valid_s;
  logic [WAYS-1:0]   way_dirty_s;
  logic [WAYS-1:0]   hit_s;
  logic [WAYS-1:0]   way_fill_s;
  logic [WAYS-1:0]   way_store_s;
  logic [TAG_W-1:0]  way_tag_s  [WAYS];
  logic [LINE_W-1:0] way_line_s [WAYS];

  logic              any_hit_s;
  logic              hit_way_s;
  logic              victim_s;
  logic [LINE_W-1:0] hit_line_s;
  logic [DATA_W-1:0] hit_word_s;
  logic [DATA_W-1:0] merged_word_s;
  logic [LINE_W-1:0] merged_line_s;
  logic [LINE_W-1:0] wr_line_s;

  // All lookups use the latched request address, not the live port.
  assign index_s = INDEX_W'(cache_index(FIELD_CALC_W'(addr_r), OFFSET_W, INDEX_W));
  assign tag_s   = TAG_W'(cache_tag(FIELD_CALC_W'(addr_r), OFFSET_W, INDEX_W));
  assign wsel_s  = WSEL_W'(cache_word(FIELD_CALC_W'(addr_r), OFFSET_W));

  assign any_hit_s  = |hit_s;
  assign hit_way_s  = hit_s[1];
  assign hit_line_s = way_line_s[hit_way_s];
  assign hit_word_s = hit_line_s[wsel_s*DATA_W +: DATA_W];

  // Prefer an empty way (way 0 first); only evict by LRU when the set is full.
  assign victim_s = !way_valid_s[0] ? 1'b0 :
                    (!way_valid_s[1] ? 1'b1 : lru_r[index_s]);

  // A fill writes the memory line; otherwise the write is a store merge.
  assign wr_line_s = (state_r == FILL) ? ddr2_data : merged_line_s;

  // Byte-masked merge of the store data into the hit line.
  always_comb begin
    merged_word_s = hit_word_s;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      if (be_r[b]) begin
        merged_word_s[b*8 +: 8] = wdata_r[b*8 +: 8];
      end else begin
        merged_word_s[b*8 +: 8] = hit_word_s[b*8 +: 8];
      end
    end
    merged_line_s = hit_line_s;
    merged_line_s[wsel_s*DATA_W +: DATA_W] = merged_word_s;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign hit_s[w]       = way_valid_s[w] && (way_tag_s[w] == tag_s);
    assign way_fill_s[w]  = (state_r == FILL) && ddr2_available && (victim_r == 1'(w));
    // A store with an empty byte mask leaves both data and dirty untouched.
    assign way_store_s[w] = (state_r == LOOKUP) && hit_s[w] && write_r && (be_r != 4'd0);

    cache_way #(
      .TAG_W   (TAG_W),
      .INDEX_W (INDEX_W),
      .LINE_W  (LINE_W),
      .SETS    (SETS)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .index    (index_s),
      .fill_en  (way_fill_s[w]),
      .store_en (way_store_s[w]),
      .wr_tag   (tag_s),
      .wr_line  (wr_line_s),
      .valid    (way_valid_s[w]),
      .dirty    (way_dirty_s[w]),
      .tag      (way_tag_s[w]),
      .line     (way_line_s[w])
    );
  end

  // Controller FSM with registered CPU and DDR2 outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      addr_r         <= '0;
      wdata_r        <= '0;
      be_r           <= 4'd0;
      write_r        <= 1'b0;
      victim_r       <= 1'b0;
      lru_r          <= '0;
      busy_r         <= 1'b0;
      available_r    <= 1'b0;
      read_data_r    <= '0;
      ddr2_addr_r    <= '0;
      to_ddr2_data_r <= '0;
      ddr2_enable_r  <= 1'b0;
      ddr2_read_r    <= 1'b0;
    end else begin
      available_r   <= 1'b0;
      ddr2_enable_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // busy_r is still high on the edge right after a completion, so a
          // request held across that edge is not taken twice.
          if (enable && !busy_r) begin
            addr_r  <= addr;
            wdata_r <= write_data;
            be_r    <= byte_en;
            write_r <= write;
            busy_r  <= 1'b1;
            state_r <= LOOKUP;
          end else begin
            busy_r <= 1'b0;
          end
        end
        LOOKUP: begin
          if (any_hit_s) begin
            lru_r[index_s] <= ~hit_way_s;
            if (!write_r) begin
              read_data_r <= hit_word_s;
            end
            state_r <= RESPOND;
          end else begin
            victim_r      <= victim_s;
            ddr2_enable_r <= 1'b1;
            if (way_valid_s[victim_s] && way_dirty_s[victim_s]) begin
              ddr2_read_r    <= 1'b0;
              ddr2_addr_r    <= {way_tag_s[victim_s], index_s, {OFFSET_W{1'b0}}};
              to_ddr2_data_r <= way_line_s[victim_s];
              state_r        <= WRITEBACK;
            end else begin
              ddr2_read_r <= 1'b1;
              ddr2_addr_r <= {tag_s, index_s, {OFFSET_W{1'b0}}};
              state_r     <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (ddr2_available) begin
            ddr2_enable_r <= 1'b1;
            ddr2_read_r   <= 1'b1;
            ddr2_addr_r   <= {tag_s, index_s, {OFFSET_W{1'b0}}};
            state_r       <= FILL;
          end
        end
        FILL: begin
          // The way arrays capture the line on this same edge (way_fill_s).
          if (ddr2_available) begin
            state_r <= LOOKUP;
          end
        end
        RESPOND: begin
          available_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_r;
  assign available    = available_r;
  assign read_data    = read_data_r;
  assign ddr2_addr    = ddr2_addr_r;
  assign to_ddr2_data = to_ddr2_data_r;
  assign ddr2_enable  = ddr2_enable_r;
  assign ddr2_read    = ddr2_read_r;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed testbench for set_assoc_cache with a DDR2 memory model and a
// scoreboard of expected memory commands and load results.
module tb_set_assoc_cache;

  localparam int MEM_LAT = 3;

  logic         clk;
  logic         rst;
  logic [26:0]  addr;
  logic [31:0]  write_data;
  logic [3:0]   byte_en;
  logic         write;
  logic         enable;
  logic         busy;
  logic [31:0]  read_data;
  logic         available;
  logic [26:0]  ddr2_addr;
  logic [127:0] to_ddr2_data;
  logic         ddr2_enable;
  logic         ddr2_read;
  logic [127:0] ddr2_data;
  logic         ddr2_available;

  set_assoc_cache dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .write_data     (write_data),
    .byte_en        (byte_en),
    .write          (write),
    .enable         (enable),
    .busy           (busy),
    .read_data      (read_data),
    .available      (available),
    .ddr2_addr      (ddr2_addr),
    .to_ddr2_data   (to_ddr2_data),
    .ddr2_enable    (ddr2_enable),
    .ddr2_read      (ddr2_read),
    .ddr2_data      (ddr2_data),
    .ddr2_available (ddr2_available)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         rd;
    logic [26:0]  a;
    logic [127:0] line;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [31:0] rdata_q[$];
  logic [31:0] shadow [int unsigned];   // architectural view of memory
  logic [31:0] mem    [int unsigned];   // DDR2 contents
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned wkey(input logic [26:0] a);
    return 32'({a[26:2], 2'b00});
  endfunction

  function automatic logic [31:0] pattern(input int unsigned k);
    return k ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [26:0] a);
    int unsigned k = wkey(a);
    return shadow.exists(k) ? shadow[k] : pattern(k);
  endfunction

  function automatic logic [31:0] mem_rd(input int unsigned k);
    return mem.exists(k) ? mem[k] : pattern(k);
  endfunction

  function automatic logic [127:0] mem_line(input logic [26:0] a);
    logic [127:0] l;
    int unsigned base = 32'({a[26:4], 4'h0});
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem_rd(base + 4*i);
    return l;
  endfunction

  task automatic shadow_wr(input logic [26:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w = shadow_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
    shadow[wkey(a)] = w;
  endtask

  task automatic expect_fill(input logic [26:0] a);
    cmd_t c;
    c.rd = 1'b1; c.a = {a[26:4], 4'h0}; c.line = '0;
    cmd_q.push_back(c);
  endtask

  task automatic expect_wb(input logic [26:0] a);
    cmd_t c;
    c.rd = 1'b0; c.a = {a[26:4], 4'h0};
    for (int i = 0; i < 4; i++) c.line[i*32 +: 32] = shadow_rd(c.a + 27'(4*i));
    cmd_q.push_back(c);
  endtask

  // One CPU request, serving DDR2 commands until the available pulse.
  // exp_lat > 0 checks edges from acceptance to available; hold = cycles enable stays high.
  task automatic txn(input logic wr, input logic [26:0] a, input logic [31:0] d,
                     input logic [3:0] be, input int exp_lat, input int hold);
    int cyc = 0; int cnt = 0; int avail_n = 0; bit done = 0;
    logic [26:0] pend = '0;
    cmd_t c;
    if (!wr) rdata_q.push_back(shadow_rd(a));
    else shadow_wr(a, d, be);
    check("busy_before_req", 128'(busy), 128'd0);
    enable = 1'b1; addr = a; write = wr; write_data = d; byte_en = be;
    while ((!done || cyc < hold) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold) enable = 1'b0;
      ddr2_available = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ddr2_available = 1'b1;
          ddr2_data = mem_line(pend);
        end
      end
      if (ddr2_enable) begin
        check("cmd_expected", 128'(cmd_q.size() != 0), 128'd1);
        if (cmd_q.size() != 0) begin
          c = cmd_q.pop_front();
          check("ddr2_read", 128'(ddr2_read), 128'(c.rd));
          check("ddr2_addr", 128'(ddr2_addr), 128'(c.a));
          if (!c.rd) check("wb_line", to_ddr2_data, c.line);
        end
        if (!ddr2_read) begin
          for (int i = 0; i < 4; i++) mem[32'(ddr2_addr) + 4*i] = to_ddr2_data[i*32 +: 32];
        end
        pend = ddr2_addr;
        cnt = MEM_LAT;
      end
      if (cyc == 1) check("busy_after_accept", 128'(busy), 128'd1);
      if (available) begin
        avail_n++;
        done = 1;
        if (exp_lat > 0) check("hit_latency", 128'(cyc - 1), 128'(exp_lat));
        if (!wr) check("read_data", 128'(read_data), 128'(rdata_q.pop_front()));
      end
    end
    enable = 1'b0;
    ddr2_available = 1'b0;
    check("completed", 128'(done), 128'd1);
    check("avail_pulses", 128'(avail_n), 128'd1);
    check("cmds_all_seen", 128'(cmd_q.size()), 128'd0);
    @(negedge clk);
    check("busy_after_done", 128'(busy), 128'd0);
    check("avail_after_done", 128'(available), 128'd0);
  endtask

  // Several idle cycles in which the cache must stay silent.
  task automatic quiet(input int n);
    int events = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (available || ddr2_enable) events++;
    end
    check("quiet_events", 128'(events), 128'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_available", 128'(available), 128'd0);
    check("rst_ddr2_enable", 128'(ddr2_enable), 128'd0);
    check("rst_ddr2_read", 128'(ddr2_read), 128'd0);
    check("rst_read_data", 128'(read_data), 128'd0);
    check("rst_ddr2_addr", 128'(ddr2_addr), 128'd0);
    check("rst_to_ddr2_data", to_ddr2_data, 128'd0);
  endtask

  initial begin
    int found;
    int avail_n;
    rst = 1'b1; enable = 1'b0; addr = '0; write = 1'b0; write_data = '0;
    byte_en = 4'h0; ddr2_data = '0; ddr2_available = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();

    // Store then load at 100: a clean fill of line 96, then a 2-cycle hit.
    expect_fill(27'd100);
    txn(1'b1, 27'd100, 32'd100, 4'hF, 0, 1);
    txn(1'b0, 27'd100, 32'd0, 4'hF, 2, 1);

    // Second dirty line in set 6, then a third tag evicts line 96.
    expect_fill(27'd4196);
    txn(1'b1, 27'd4196, 32'h0000_1234, 4'hF, 0, 1);
    expect_wb(27'd96);
    expect_fill(27'd8292);
    txn(1'b1, 27'd8292, 32'h0000_5555, 4'hF, 0, 1);
    txn(1'b0, 27'd4196, 32'd0, 4'hF, 2, 1);

    // Byte-masked store merge, and an empty mask that changes nothing.
    expect_fill(27'h200);
    txn(1'b1, 27'h200, 32'hAABB_CCDD, 4'hF, 0, 1);
    txn(1'b1, 27'h200, 32'h0000_0011, 4'h1, 2, 1);
    txn(1'b0, 27'h200, 32'd0, 4'hF, 2, 1);
    txn(1'b1, 27'h200, 32'hFFFF_FFFF, 4'h0, 2, 1);
    txn(1'b0, 27'h200, 32'd0, 4'hF, 2, 1);

    // Load miss returns memory data.
    expect_fill(27'h304);
    txn(1'b0, 27'h304, 32'd0, 4'hF, 0, 1);

    // Enable held for 6 cycles across a miss: one transaction only.
    expect_fill(27'h404);
    txn(1'b0, 27'h404, 32'd0, 4'hF, 0, 6);
    quiet(5);

    // Reset one cycle after a fill strobe; the late acknowledge is ignored.
    enable = 1'b1; addr = 27'h500; write = 1'b0; byte_en = 4'hF;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      enable = 1'b0;
      if (ddr2_enable) found = 1;
    end
    check("rst_test_fill_strobe", 128'(found), 128'd1);
    check("rst_test_fill_addr", 128'(ddr2_addr), 128'h500);
    check("rst_test_fill_read", 128'(ddr2_read), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();
    ddr2_data = mem_line(27'h500);
    ddr2_available = 1'b1;
    avail_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ddr2_available = 1'b0;
      if (available) avail_n++;
    end
    check("rst_no_avail", 128'(avail_n), 128'd0);
    check("rst_busy_low", 128'(busy), 128'd0);
    expect_fill(27'd100);
    txn(1'b0, 27'd100, 32'd0, 4'hF, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, CPU word width; fixed at 32.
REQ-003 SHALL have parameter LINE_W, default 128, line and DDR2 beat width; a power-of-two multiple of DATA_W.
REQ-004 SHALL have parameter SETS, default 256, set count; a power of two.
REQ-005 SHALL have parameter WAYS, default 2, associativity; fixed at 2 (single LRU bit per set).
REQ-006 SHALL have port clk, in, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, in, 1, synchronous active-high reset.
REQ-008 SHALL have port addr, in, ADDR_W, byte address; addr[1:0] ignored.
REQ-009 SHALL have port write_data, in, DATA_W, store data.
REQ-010 SHALL have port byte_en, in, 4, store byte mask.
REQ-011 SHALL have port write, in, 1, 1 = store, 0 = load.
REQ-012 SHALL have port enable, in, 1, request strobe.
REQ-013 SHALL have port busy, out, 1, request not acceptable this cycle.
REQ-014 SHALL have port read_data, out, DATA_W, load result.
REQ-015 SHALL have port available, out, 1, one-cycle completion pulse for loads and stores.
REQ-016 SHALL have port ddr2_addr, out, ADDR_W, line-aligned memory address.
REQ-017 SHALL have port to_ddr2_data, out, LINE_W, write-back line.
REQ-018 SHALL have port ddr2_enable, out, 1, one-cycle memory command strobe.
REQ-019 SHALL have port ddr2_read, out, 1, 1 = line fill, 0 = line write.
REQ-020 SHALL have port ddr2_data, in, LINE_W, fill data, valid with ddr2_available.
REQ-021 SHALL have port ddr2_available, in, 1, one-cycle acknowledge for both read and write commands.

Function
REQ-022 SHALL decode addresses as: offset = low log2(LINE_W/8) bits (word select = offset[MSB:2]); index = next log2(SETS) bits; tag = remaining upper bits.
REQ-023 SHALL accept a request on an edge where enable=1 and busy=0; enable while busy=1 SHALL be ignored.
REQ-024 SHALL keep busy=1 from the accepting edge until the edge after the available pulse.
REQ-025 SHALL use FSM states IDLE, LOOKUP, WRITEBACK, FILL and RESPOND.
REQ-026 SHALL transition IDLE->LOOKUP on acceptance, latching addr, write_data, byte_en and write.
REQ-027 SHALL, on a LOOKUP hit, pulse available in the next cycle (RESPOND), giving hit latency of 2 cycles from acceptance edge to available high.
REQ-028 SHALL, on a LOOKUP miss, select the victim as an invalid way if any (way 0 first), otherwise the LRU way.
REQ-029 SHALL go to WRITEBACK if the victim is valid and dirty, otherwise to FILL.
REQ-030 SHALL in WRITEBACK pulse ddr2_enable=1 and ddr2_read=0 for one cycle, with the victim line address and data, then wait for ddr2_available before entering FILL.
REQ-031 SHALL in FILL pulse ddr2_enable=1 and ddr2_read=1 for one cycle with the request line address, then wait for ddr2_available.
REQ-032 SHALL on fill acknowledge write ddr2_data into the victim way, set valid=1, dirty=0 and the tag, then enter LOOKUP again; the retried lookup is guaranteed to hit.
REQ-033 SHALL on a store hit merge write_data into the selected word per byte_en and set dirty=1; byte_en=0 SHALL complete with the data and dirty bit unchanged.
REQ-034 SHALL drive read_data with the addressed word on a load and hold it until the next available pulse; read_data is don't-care for stores.
REQ-035 SHALL on every hit set the set's LRU bit to point at the other way.
REQ-036 SHALL ignore a ddr2_available that arrives outside WRITEBACK or FILL.
REQ-037 SHALL have each transaction issue at most one write-back and one fill.

Reset
REQ-038 SHALL clear every valid, dirty and LRU bit on rst and force the FSM to IDLE; tags and data SHALL be left uninitialised.
REQ-039 SHALL reset outputs to busy=0, available=0, ddr2_enable=0, ddr2_read=0, read_data=0, ddr2_addr=0 and to_ddr2_data=0.
REQ-040 SHALL, when rst arrives mid-miss, abandon the transaction, produce no available pulse, and ignore any later ddr2_available.

Structure
REQ-041 SHALL place the state enum, the address-field width localparams and the tag/index/offset extraction functions in package cache_pkg.
REQ-042 SHALL implement each way's tag/valid/dirty/data storage in one sub-module, cache_way, instantiated WAYS times; the LRU array stays in the top module.

Verification
REQ-043 SHALL test: store 100 at addr 100 (byte_en=F), then load addr 100 -> first access does a FILL at ddr2_addr 96 with no WRITEBACK; the load hits with available 2 cycles after acceptance and read_data=100.
REQ-044 SHALL test: with dirty stores at addr 100 and 4196, a store to 8292 -> WRITEBACK of line 96 containing word 100, then FILL of 8288.
REQ-045 SHALL test: store 0xAABBCCDD, then store 0x11 with byte_en=1 to the same address -> a load returns 0xAABBCC11.
REQ-046 SHALL test: assert rst one cycle after the FILL strobe, then inject ddr2_available -> no available pulse, busy=0, and a load of addr 100 misses.
REQ-047 SHALL test: enable held high for 6 cycles during a miss -> exactly one transaction and one available pulse.
